// File: rtl/demux_stream_n.sv
// demux_stream_n: a registered 1:N stream demultiplexer with valid/ready flow control.
// One word is held at a time. It is released to one channel, or broadcast to all
// channels, and stays held until every targeted consumer has accepted it. Words
// addressed to a channel that does not exist are dropped and counted.
module demux_stream_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  output logic [N_OUT-1:0]  o_valid,
  input  logic [N_OUT-1:0]  o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  // The channel count is widened by one bit so that N_OUT == 2**SEL_W still fits.
  localparam logic [SEL_W:0] LP_N_OUT = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0]  r_pend;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_done;
  logic              w_accept;
  logic              w_sel_ok;
  logic [N_OUT-1:0]  w_load_mask;
  logic [N_OUT-1:0]  w_pend_nxt;

  // The held word is finished once every pending channel is empty or handshaking now.
  // in_ready depends only on state and o_ready; in_valid never feeds back into it.
  assign w_done   = ((r_pend & ~o_ready) == '0);
  assign in_ready = w_done;
  assign w_accept = in_valid & w_done;
  assign w_sel_ok = ({1'b0, in_sel} < LP_N_OUT);

  // Build the destination mask for an incoming word, then pick the next pending mask.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    w_load_mask = '0;
    w_pend_nxt  = r_pend & ~o_ready;
    if (in_bcast) begin
      w_load_mask = '1;
    end else if (w_sel_ok) begin
      w_load_mask = N_OUT'(1) << in_sel;
    end
    // On a refill the old bits are all handshaking this cycle (w_done), so the new
    // mask simply replaces them with no bubble in between.
    if (w_accept) begin
      w_pend_nxt = w_load_mask;
    end
  end

  // Pending mask, held payload and drop counter; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples
    // the values from before this edge, independent of statement order.
    if (!rst_n) begin
      r_pend     <= '0;
      r_data     <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      // The payload only changes on accept, so it stays stable while any bit is pending.
      if (w_accept) begin
        r_data <= in_data;
      end
      if (w_accept && !in_bcast && !w_sel_ok && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign o_valid  = r_pend;
  assign o_data   = r_data;
  assign drop_cnt = r_drop_cnt;

endmodule
